// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes; signs applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, dz, qneg, rneg;

  logic               start_ok, sgn, opb_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     msum, shifted, diff;
  logic [2*WIDTH-1:0] mul_acc, div_acc;
  logic [WIDTH-1:0]   quo, rem;

  assign start_ok = start & ~cancel;
  assign sgn      = ~op[0];
  assign opb_zero = (opb == '0);
  assign a_mag    = (sgn & opa[WIDTH-1]) ? -opa : opa;
  assign b_mag    = (sgn & opb[WIDTH-1]) ? -opb : opb;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_acc = {msum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits shifting out / quotient bits in}
  assign shifted = acc[2*WIDTH-1:WIDTH-1];
  assign diff    = shifted - {1'b0, opnd};
  assign div_acc = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};

  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = (op[1] && opb_zero) ? FIX : RUN;
      RUN: begin
        if (cancel)          state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt    <= '0;
            is_div <= op[1];
            dz     <= op[1] & opb_zero;
            qneg   <= sgn & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rneg   <= sgn & opa[WIDTH-1];
            // Divide-by-zero parks the raw dividend in the HI half for FIX
            if (op[1] && opb_zero) begin
              acc <= {opa, {WIDTH{1'b0}}};
            end else if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else if (!start) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          if (cancel) begin
            cnt <= '0;
          end else begin
            acc <= is_div ? div_acc : mul_acc;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          cnt <= '0;
          if (!cancel) begin
            done        <= 1'b1;
            div_by_zero <= dz;
            if (dz) begin
              hi <= rem;
              lo <= '1;
            end else if (is_div) begin
              lo <= qneg ? -quo : quo;
              hi <= rneg ? -rem : rem;
            end else begin
              {hi, lo} <= qneg ? -acc : acc;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
